// File: rtl/button_pkg.sv
// Shared button indices and auto-repeat state encoding for the push-button front end
// and its consumers (the seven-segment digit editor uses the same indices).
package button_pkg;

  localparam int NUM_BUTTONS = 5;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;
  localparam int BTN_C = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-flop synchronizer, restart-on-bounce debouncer,
// press/release pulses and an optional hold-to-repeat pulse generator.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_nxt;
  logic          accept;
  logic [DW-1:0] db_cnt;
  rpt_state_t    state;
  logic [RW-1:0] rpt_cnt;

  // Stage 1: bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button_raw;
      sync2 <= sync1;
    end
  end

  assign accept     = (sync2 != stable) && (db_cnt == DB_LAST);
  assign stable_nxt = accept ? sync2 : stable;

  // Stage 2: debounce; any return to the stable value restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable        <= 1'b0;
      db_cnt        <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= accept & sync2;
      release_pulse <= accept & ~sync2;
      if (sync2 == stable) begin
        db_cnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  assign level = stable;

  // Stage 3: auto-repeat, driven off the accepted level so a release edge never repeats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rpt_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else if (!REPEAT_EN || !stable_nxt) begin
      state        <= IDLE;
      rpt_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= DELAY;
            rpt_cnt <= '0;
          end
        end
        DELAY: begin
          if (rpt_cnt == DELAY_LAST) begin
            repeat_pulse <= 1'b1;
            rpt_cnt      <= '0;
            state        <= REPEAT;
          end else begin
            rpt_cnt <= rpt_cnt + RW'(1);
          end
        end
        REPEAT: begin
          if (rpt_cnt == PERIOD_LAST) begin
            repeat_pulse <= 1'b1;
            rpt_cnt      <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + RW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          rpt_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end for the digit editor: one independent conditioning
// channel per button, bit order L, R, U, D, C.
module button_conditioner #(
  parameter int                           NUM_BUTTONS     = button_pkg::NUM_BUTTONS,
  parameter int                           DEBOUNCE_CYCLES = 1000000,
  parameter int                           REPEAT_DELAY    = 50000000,
  parameter int                           REPEAT_PERIOD   = 10000000,
  parameter logic [NUM_BUTTONS-1:0]       REPEAT_MASK     = 5'b01100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic [NUM_BUTTONS-1:0] btn_repeat,
  output logic                   btn_any_press
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .button_raw    (buttons_raw[i]),
      .level         (btn_level[i]),
      .press_pulse   (btn_press[i]),
      .release_pulse (btn_release[i]),
      .repeat_pulse  (btn_repeat[i])
    );
  end

  assign btn_any_press = |btn_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timings;
// expected output vectors are queued per cycle and compared on the falling edge.
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic [4:0] buttons_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [4:0] btn_release;
  logic [4:0] btn_repeat;
  logic       btn_any_press;

  int tests;
  int failed;
  int cyc;

  typedef struct {
    int         cyc;
    string      tag;
    logic [4:0] lvl;
    logic [4:0] prs;
    logic [4:0] rel;
    logic [4:0] rpt;
    logic       any;
  } exp_t;

  exp_t sb[$];

  button_conditioner #(
    .NUM_BUTTONS     (5),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3),
    .REPEAT_MASK     (5'b01100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .buttons_raw   (buttons_raw),
    .btn_level     (btn_level),
    .btn_press     (btn_press),
    .btn_release   (btn_release),
    .btn_repeat    (btn_repeat),
    .btn_any_press (btn_any_press)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int off, input string tag, input logic [4:0] lvl,
                      input logic [4:0] prs, input logic [4:0] rel, input logic [4:0] rpt);
    exp_t e;
    e.cyc = cyc + off;
    e.tag = tag;
    e.lvl = lvl;
    e.prs = prs;
    e.rel = rel;
    e.rpt = rpt;
    e.any = |prs;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        tests++;
        assert (btn_level === sb[i].lvl && btn_press === sb[i].prs &&
                btn_release === sb[i].rel && btn_repeat === sb[i].rpt &&
                btn_any_press === sb[i].any)
        else begin
          failed++;
          $error("FAIL %s cyc=%0d observed lvl=%b prs=%b rel=%b rpt=%b any=%b expected lvl=%b prs=%b rel=%b rpt=%b any=%b",
                 sb[i].tag, cyc, btn_level, btn_press, btn_release, btn_repeat, btn_any_press,
                 sb[i].lvl, sb[i].prs, sb[i].rel, sb[i].rpt, sb[i].any);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        tests++;
        failed++;
        $error("FAIL %s_missed observed cyc=%0d expected cyc=%0d", sb[i].tag, cyc, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    int         base;
    int         guard;
    logic [4:0] lvl, prs, rel, rpt;
    logic [7:0] pat;

    tests       = 0;
    failed      = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    buttons_raw = 5'b00000;

    // Reset and first cycle after it.
    step(2);
    push(0, "reset_hold", 5'b0, 5'b0, 5'b0, 5'b0);
    rst_n = 1'b1;
    push(1, "after_reset", 5'b0, 5'b0, 5'b0, 5'b0);
    step(1);

    // Clean press/release on L (not repeat-enabled).
    base = cyc;
    buttons_raw = 5'b00001;
    for (int c = 0; c < 22; c++) begin
      lvl = (c >= 6) ? 5'b00001 : 5'b00000;
      prs = (c == 6) ? 5'b00001 : 5'b00000;
      push(c, "clean_press", lvl, prs, 5'b0, 5'b0);
    end
    step(22);
    buttons_raw = 5'b00000;
    for (int c = 0; c < 9; c++) begin
      lvl = (c < 6) ? 5'b00001 : 5'b00000;
      rel = (c == 6) ? 5'b00001 : 5'b00000;
      push(c, "clean_release", lvl, 5'b0, rel, 5'b0);
    end
    step(9);

    // Bounce on C: runs of 3 are rejected, a steady level is accepted.
    base = cyc;
    for (int c = 0; c < 14; c++) push(c, "bounce_reject", 5'b0, 5'b0, 5'b0, 5'b0);
    push(14, "bounce_accept", 5'b10000, 5'b10000, 5'b0, 5'b0);
    push(15, "bounce_hold", 5'b10000, 5'b0, 5'b0, 5'b0);
    pat = 8'b0111_0111;
    for (int i = 0; i < 8; i++) begin
      buttons_raw[4] = pat[i];
      step(1);
    end
    buttons_raw[4] = 1'b1;
    step(8);
    buttons_raw = 5'b00000;
    for (int c = 0; c < 8; c++) begin
      lvl = (c < 6) ? 5'b10000 : 5'b00000;
      rel = (c == 6) ? 5'b10000 : 5'b00000;
      push(c, "bounce_release", lvl, 5'b0, rel, 5'b0);
    end
    step(8);

    // Auto-repeat on U held for 40 cycles; the release edge itself must not repeat.
    base = cyc;
    buttons_raw = 5'b00100;
    for (int c = 0; c < 56; c++) begin
      lvl = (c >= 6 && c < 46) ? 5'b00100 : 5'b00000;
      prs = (c == 6) ? 5'b00100 : 5'b00000;
      rel = (c == 46) ? 5'b00100 : 5'b00000;
      rpt = (c >= 16 && c <= 43 && ((c - 16) % 3) == 0) ? 5'b00100 : 5'b00000;
      push(c, "auto_repeat", lvl, prs, rel, rpt);
    end
    step(40);
    buttons_raw = 5'b00000;
    step(16);

    // R and D together: shared press cycle, only D repeats.
    base = cyc;
    buttons_raw = 5'b01010;
    for (int c = 0; c < 28; c++) begin
      lvl = (c >= 6 && c < 24) ? 5'b01010 : 5'b00000;
      prs = (c == 6) ? 5'b01010 : 5'b00000;
      rel = (c == 24) ? 5'b01010 : 5'b00000;
      rpt = (c == 16 || c == 19 || c == 22) ? 5'b01000 : 5'b00000;
      push(c, "simultaneous", lvl, prs, rel, rpt);
    end
    step(18);
    buttons_raw = 5'b00000;
    step(10);

    // Reset while U is held in the repeating phase.
    base = cyc;
    buttons_raw = 5'b00100;
    for (int c = 0; c < 17; c++) begin
      lvl = (c >= 6) ? 5'b00100 : 5'b00000;
      prs = (c == 6) ? 5'b00100 : 5'b00000;
      rpt = (c == 16) ? 5'b00100 : 5'b00000;
      push(c, "pre_reset_hold", lvl, prs, 5'b0, rpt);
    end
    step(17);
    rst_n = 1'b0;
    #1;
    tests++;
    assert ({btn_level, btn_press, btn_release, btn_repeat, btn_any_press} === 21'd0)
    else begin
      failed++;
      $error("FAIL async_reset observed %b expected 0",
             {btn_level, btn_press, btn_release, btn_repeat, btn_any_press});
    end
    push(0, "in_reset", 5'b0, 5'b0, 5'b0, 5'b0);
    push(1, "in_reset", 5'b0, 5'b0, 5'b0, 5'b0);
    step(2);
    rst_n = 1'b1;
    for (int c = 0; c < 26; c++) begin
      lvl = (c >= 6 && c < 23) ? 5'b00100 : 5'b00000;
      prs = (c == 6) ? 5'b00100 : 5'b00000;
      rel = (c == 23) ? 5'b00100 : 5'b00000;
      rpt = (c == 16 || c == 19 || c == 22) ? 5'b00100 : 5'b00000;
      push(c, "post_reset_hold", lvl, prs, rel, rpt);
    end
    step(17);
    buttons_raw = 5'b00000;
    step(9);

    // D released while still in the initial delay: no repeat at all.
    base = cyc;
    buttons_raw = 5'b01000;
    for (int c = 0; c < 22; c++) begin
      lvl = (c >= 6 && c < 14) ? 5'b01000 : 5'b00000;
      prs = (c == 6) ? 5'b01000 : 5'b00000;
      rel = (c == 14) ? 5'b01000 : 5'b00000;
      push(c, "release_in_delay", lvl, prs, rel, 5'b0);
    end
    step(8);
    buttons_raw = 5'b00000;
    step(14);

    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      step(1);
      guard++;
    end
    tests++;
    assert (sb.size() == 0)
    else begin
      failed++;
      $error("FAIL drain observed %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
